if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue_pkg.sv | 16 +
 rtl/if_fetch_queue_if.sv | 33 +++
 rtl/if_fetch_queue_fetch_fifo.sv | 62 ++++++
 rtl/if_fetch_queue.sv | 113 +++++++++++
 tb/tb_if_fetch_queue.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch definitions: instruction-source select and fetch-queue entry.
// Imported by the fetch queue top, its FIFO and the bus interface.
package if_fetch_queue_pkg;

  localparam logic INST_IMEM = 1'b0;
  localparam logic INST_BIOS = 1'b1;

  localparam int FETCH_ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic        sel;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch queue bus: memory request/response, ID handshake and redirects.
// master = fetch unit side, slave = the ID/WB/memory side.
interface if_fetch_queue_if;

  logic        id_ready;
  logic [31:0] id_target;
  logic        id_target_taken;
  logic [31:0] wb_redirect;
  logic        wb_flush;
  logic [31:0] if_inst;
  logic [31:0] if_addr;
  logic        if_bios_en;
  logic        if_req;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_inst_sel;

  modport master (
    input  id_ready, id_target, id_target_taken,
    input  wb_redirect, wb_flush, if_inst,
    output if_addr, if_bios_en, if_req,
    output id_valid, id_pc, id_inst, id_inst_sel
  );

  modport slave (
    output id_ready, id_target, id_target_taken,
    output wb_redirect, wb_flush, if_inst,
    input  if_addr, if_bios_en, if_req,
    input  id_valid, id_pc, id_inst, id_inst_sel
  );

endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Fetch entry FIFO: DEPTH-wrapping pointers, synchronous clear.
// Storage is not reset; head data is only meaningful while count != 0.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: PC, single in-flight request, entry FIFO.
// Optional IF_FETCH_STALL_CNT_EN adds the stall_cycles counter output.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          DEPTH    = 4,
  parameter int          BIOS_BIT = 30
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IF_FETCH_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  if_fetch_queue_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             infl_v_q, infl_v_d;
  logic [31:0]      infl_pc_q, infl_pc_d;
  logic             infl_sel_q, infl_sel_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  logic             redirect;
  logic             req;
  logic             valid;
  logic             push;
  logic             pop;
  fetch_entry_t     wr_e;
  fetch_entry_t     rd_e;

  always_comb begin
    redirect = bus.wb_flush | bus.id_target_taken;
    // In-flight request already owns a slot, so the FIFO can never overflow
    occ   = {1'b0, count} + {{CNT_W{1'b0}}, infl_v_q};
    req   = !rst && !redirect && (occ < DEPTH_C);
    valid = !rst && (count != '0);
    pop   = valid && bus.id_ready && !redirect;
    push  = !rst && infl_v_q && !redirect;

    pc_d = pc_q;
    if (redirect)
      pc_d = bus.wb_flush ? bus.wb_redirect : bus.id_target;
    else if (req)
      pc_d = pc_q + 32'd4;

    infl_v_d   = req;
    infl_pc_d  = req ? pc_q : infl_pc_q;
    infl_sel_d = infl_sel_q;
    if (req)
      infl_sel_d = pc_q[BIOS_BIT] ? INST_BIOS : INST_IMEM;

    wr_e.pc   = infl_pc_q;
    wr_e.sel  = infl_sel_q;
    wr_e.inst = bus.if_inst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      infl_v_q   <= 1'b0;
      infl_pc_q  <= '0;
      infl_sel_q <= INST_IMEM;
    end else begin
      pc_q       <= pc_d;
      infl_v_q   <= infl_v_d;
      infl_pc_q  <= infl_pc_d;
      infl_sel_q <= infl_sel_d;
    end
  end

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (redirect),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_e),
    .rd_data (rd_e),
    .count   (count)
  );

  assign bus.if_req      = req;
  assign bus.if_addr     = pc_q;
  assign bus.if_bios_en  = pc_q[BIOS_BIT];
  assign bus.id_valid    = valid;
  assign bus.id_pc       = rd_e.pc;
  assign bus.id_inst     = rd_e.inst;
  assign bus.id_inst_sel = rd_e.sel;

`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid && !bus.id_ready) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed vector bench for if_fetch_queue (DEPTH=4).
// Memory model returns addr ^ K one cycle after each address.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam logic [31:0] B = 32'h4000_0000;
  localparam logic [31:0] K = 32'hA5A5_0F0F;
  localparam int NV = 28;

  typedef struct {
    logic        r;
    logic        rdy;
    logic        tt;
    logic        fl;
    logic [31:0] tgt;
    logic [31:0] rdr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] cap_addr = '0;
  vec_t v [NV];

  if_fetch_queue_if bus ();

`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  if_fetch_queue #(
    .RESET_PC (B),
    .DEPTH    (4),
    .BIOS_BIT (30)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef IF_FETCH_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) cap_addr <= bus.if_addr;

  function automatic vec_t mk(
    input logic r, input logic rdy, input logic tt, input logic fl,
    input logic [31:0] tgt, input logic [31:0] rdr,
    input logic e_req, input logic [31:0] e_addr,
    input logic e_valid, input logic [31:0] e_pc);
    vec_t t;
    t.r = r; t.rdy = rdy; t.tt = tt; t.fl = fl;
    t.tgt = tgt; t.rdr = rdr;
    t.e_req = e_req; t.e_addr = e_addr;
    t.e_valid = e_valid; t.e_pc = e_pc;
    return t;
  endfunction

  task automatic drive(
    input logic r, input logic rdy, input logic tt, input logic fl,
    input logic [31:0] tgt, input logic [31:0] rdr);
    @(posedge clk);
    #1;
    rst                 = r;
    bus.id_ready        = rdy;
    bus.id_target_taken = tt;
    bus.id_target       = tgt;
    bus.wb_flush        = fl;
    bus.wb_redirect     = rdr;
    bus.if_inst         = cap_addr ^ K;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, " id_valid"}, 32'(bus.id_valid), 32'd1);
    chk({tag, " id_pc"}, bus.id_pc, pc);
    chk({tag, " id_inst"}, bus.id_inst, pc ^ K);
    chk({tag, " id_inst_sel"}, 32'(bus.id_inst_sel),
        32'(pc[30] ? INST_BIOS : INST_IMEM));
  endtask

  initial begin
    bus.id_ready        = 1'b0;
    bus.id_target_taken = 1'b0;
    bus.id_target       = '0;
    bus.wb_flush        = 1'b0;
    bus.wb_redirect     = '0;
    bus.if_inst         = '0;

    v[0]  = mk(1,1,0,0,0,0,            0, B,          0, 0);
    v[1]  = mk(1,0,0,0,0,0,            0, B,          0, 0);
    v[2]  = mk(0,0,0,0,0,0,            1, B,          0, 0);
    v[3]  = mk(0,0,0,0,0,0,            1, B+4,        0, 0);
    v[4]  = mk(0,0,0,0,0,0,            1, B+8,        1, B);
    v[5]  = mk(0,0,0,0,0,0,            1, B+12,       1, B);
    v[6]  = mk(0,0,0,0,0,0,            0, B+16,       1, B);
    v[7]  = mk(0,0,0,0,0,0,            0, B+16,       1, B);
    v[8]  = mk(0,1,0,0,0,0,            0, B+16,       1, B);
    v[9]  = mk(0,0,0,0,0,0,            1, B+16,       1, B+4);
    v[10] = mk(0,0,0,0,0,0,            0, B+20,       1, B+4);
    v[11] = mk(0,0,0,0,0,0,            0, B+20,       1, B+4);
    v[12] = mk(0,0,1,0,32'h1000,0,     0, B+20,       1, B+4);
    v[13] = mk(0,1,0,0,0,0,            1, 32'h1000,   0, 0);
    v[14] = mk(0,1,0,0,0,0,            1, 32'h1004,   0, 0);
    v[15] = mk(0,1,0,0,0,0,            1, 32'h1008,   1, 32'h1000);
    v[16] = mk(0,1,1,1,32'h3000,32'h2000, 0, 32'h100C, 1, 32'h1004);
    v[17] = mk(0,1,0,0,0,0,            1, 32'h2000,   0, 0);
    v[18] = mk(0,1,0,0,0,0,            1, 32'h2004,   0, 0);
    v[19] = mk(0,1,0,0,0,0,            1, 32'h2008,   1, 32'h2000);
    v[20] = mk(0,1,0,0,0,0,            1, 32'h200C,   1, 32'h2004);
    v[21] = mk(0,0,0,0,0,0,            1, 32'h2010,   1, 32'h2008);
    v[22] = mk(0,0,0,0,0,0,            1, 32'h2014,   1, 32'h2008);
    v[23] = mk(1,0,0,1,0,32'h5000,     0, 32'h2018,   0, 0);
    v[24] = mk(0,0,0,0,0,0,            1, B,          0, 0);
    v[25] = mk(0,0,0,0,0,0,            1, B+4,        0, 0);
    v[26] = mk(0,1,0,0,0,0,            1, B+8,        1, B);
    v[27] = mk(0,1,0,0,0,0,            1, B+12,       1, B+4);

    for (int i = 0; i < NV; i++) begin
      drive(v[i].r, v[i].rdy, v[i].tt, v[i].fl, v[i].tgt, v[i].rdr);
      chk($sformatf("v%0d if_req", i), 32'(bus.if_req), 32'(v[i].e_req));
      chk($sformatf("v%0d if_addr", i), bus.if_addr, v[i].e_addr);
      chk($sformatf("v%0d if_bios_en", i), 32'(bus.if_bios_en),
          32'(v[i].e_addr[30]));
      chk($sformatf("v%0d id_valid", i), 32'(bus.id_valid),
          32'(v[i].e_valid));
      if (v[i].e_valid)
        chk_head($sformatf("v%0d", i), v[i].e_pc);
    end

    // Held head across a long stall, then redirect with ready high
    drive(1, 1, 0, 0, 0, 0);
    chk("stall rst id_valid", 32'(bus.id_valid), 32'd0);
    for (int s = 1; s <= 9; s++) begin
      drive(0, 0, 0, 0, 0, 0);
`ifdef IF_FETCH_STALL_CNT_EN
      if (s == 1) chk("stall cleared", stall_cycles, 32'd0);
`endif
      if (s >= 3) chk_head($sformatf("stall s%0d", s), B);
    end
    drive(0, 1, 1, 0, 32'h4000_0100, 0);
    chk_head("redir", B);
    chk("redir if_req", 32'(bus.if_req), 32'd0);
`ifdef IF_FETCH_STALL_CNT_EN
    chk("stall_cycles 7", stall_cycles, 32'd7);
`endif
    drive(0, 1, 0, 0, 0, 0);
    chk("post id_valid", 32'(bus.id_valid), 32'd0);
    chk("post if_addr", bus.if_addr, 32'h4000_0100);
`ifdef IF_FETCH_STALL_CNT_EN
    chk("stall kept", stall_cycles, 32'd7);
`endif
    drive(0, 1, 0, 0, 0, 0);
    chk("post2 if_addr", bus.if_addr, 32'h4000_0104);
    drive(0, 1, 0, 0, 0, 0);
    chk_head("post3", 32'h4000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
